// File: rtl/guitar_effect_regs.sv
// Avalon-MM register bank for the guitar effect: distortion settings, status/control,
// and one-deep ADC input / DAC output sample mailboxes.
module guitar_effect_regs #(
    parameter int          DW       = 16,
    parameter logic [31:0] GAIN_RST = 32'd1,
    parameter logic [31:0] ID_VALUE = 32'h4755_0001
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    avl_address,
    input  logic          avl_read,
    input  logic          avl_write,
    input  logic [31:0]   avl_writedata,
    output logic [31:0]   avl_readdata,
    input  logic [DW-1:0] adc_sample,
    input  logic          adc_valid,
    output logic [DW-1:0] dac_sample,
    output logic          dac_valid,
    input  logic          dac_ready,
    output logic [31:0]   cfg_gain,
    output logic [31:0]   cfg_boost,
    output logic          cfg_bypass
);

    localparam logic [4:0] ADDR_ID      = 5'h00;
    localparam logic [4:0] ADDR_GAIN    = 5'h01;
    localparam logic [4:0] ADDR_BOOST   = 5'h02;
    localparam logic [4:0] ADDR_STATUS  = 5'h03;
    localparam logic [4:0] ADDR_CONTROL = 5'h04;
    localparam logic [4:0] ADDR_INPUT   = 5'h06;
    localparam logic [4:0] ADDR_OUTPUT  = 5'h05;

    logic [31:0]   gain;
    logic [31:0]   boost;
    logic          enable;
    logic          bypass;
    logic          in_avail;
    logic          in_overrun;
    logic          out_overrun;
    logic [DW-1:0] in_sample;

    logic          rd_en;
    logic          rd_input;
    logic          adc_take;
    logic          status_wr;
    logic          out_wr;
    logic          out_load;
    logic          out_drop;
    logic [31:0]   in_ext;
    logic [31:0]   status;
    logic [31:0]   rd_mux;

    // A simultaneous write suppresses the read entirely.
    assign rd_en     = avl_read & ~avl_write;
    assign rd_input  = rd_en & (avl_address == ADDR_INPUT);
    assign adc_take  = enable & adc_valid;
    assign status_wr = avl_write & (avl_address == ADDR_STATUS);
    assign out_wr    = avl_write & (avl_address == ADDR_OUTPUT);
    assign out_load  = out_wr & (~dac_valid | dac_ready);
    assign out_drop  = out_wr & dac_valid & ~dac_ready;

    assign in_ext = {{(33-DW){in_sample[DW-1]}}, in_sample[DW-2:0]};
    assign status = {28'd0, out_overrun, dac_valid, in_overrun, in_avail};

    always_comb begin
        rd_mux = 32'd0;
        case (avl_address)
            ADDR_ID:      rd_mux = ID_VALUE;
            ADDR_GAIN:    rd_mux = gain;
            ADDR_BOOST:   rd_mux = boost;
            ADDR_STATUS:  rd_mux = status;
            ADDR_CONTROL: rd_mux = {30'd0, bypass, enable};
            ADDR_INPUT:   rd_mux = in_ext;
            default:      rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avl_readdata <= 32'd0;
            gain         <= GAIN_RST;
            boost        <= 32'd0;
            enable       <= 1'b0;
            bypass       <= 1'b0;
            in_avail     <= 1'b0;
            in_overrun   <= 1'b0;
            out_overrun  <= 1'b0;
            in_sample    <= '0;
            dac_sample   <= '0;
            dac_valid    <= 1'b0;
        end else begin
            if (rd_en)
                avl_readdata <= rd_mux;

            if (avl_write && avl_address == ADDR_GAIN)
                gain <= avl_writedata;
            if (avl_write && avl_address == ADDR_BOOST)
                boost <= avl_writedata;
            if (avl_write && avl_address == ADDR_CONTROL) begin
                enable <= avl_writedata[0];
                bypass <= avl_writedata[1];
            end

            // A fresh sample arriving alongside the draining read keeps the mailbox full.
            if (adc_take) begin
                in_sample <= adc_sample;
                in_avail  <= 1'b1;
            end else if (rd_input) begin
                in_avail  <= 1'b0;
            end

            // Set terms are OR'd after the clear so a coincident set wins.
            in_overrun  <= (adc_take & in_avail & ~rd_input) |
                           (in_overrun & ~(status_wr & avl_writedata[1]));
            out_overrun <= out_drop |
                           (out_overrun & ~(status_wr & avl_writedata[3]));

            if (out_load) begin
                dac_sample <= avl_writedata[DW-1:0];
                dac_valid  <= 1'b1;
            end else if (dac_valid && dac_ready) begin
                dac_valid  <= 1'b0;
            end
        end
    end

    assign cfg_gain   = gain;
    assign cfg_boost  = boost;
    assign cfg_bypass = bypass;

endmodule

// File: tb/tb_guitar_effect_regs.sv
// Self-checking bench for guitar_effect_regs: directed scenarios plus a randomized
// run against a mailbox/queue-level reference model.
module tb_guitar_effect_regs;

    localparam int DW = 16;
    localparam logic [31:0] ID = 32'h4755_0001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    avl_address = '0;
    logic          avl_read = 1'b0;
    logic          avl_write = 1'b0;
    logic [31:0]   avl_writedata = '0;
    logic [31:0]   avl_readdata;
    logic [DW-1:0] adc_sample = '0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] dac_sample;
    logic          dac_valid;
    logic          dac_ready = 1'b0;
    logic [31:0]   cfg_gain;
    logic [31:0]   cfg_boost;
    logic          cfg_bypass;

    int n_cmp = 0;
    int n_err = 0;

    guitar_effect_regs #(.DW(DW), .GAIN_RST(32'd1), .ID_VALUE(ID)) dut (
        .clk(clk), .reset(reset),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_writedata(avl_writedata), .avl_readdata(avl_readdata),
        .adc_sample(adc_sample), .adc_valid(adc_valid),
        .dac_sample(dac_sample), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .cfg_gain(cfg_gain), .cfg_boost(cfg_boost), .cfg_bypass(cfg_bypass)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sext(input logic [DW-1:0] v);
        int s;
        s = $signed(v);
        return 32'(s);
    endfunction

    // One bus cycle: drive at a falling edge, let the rising edge sample, return at the next falling edge.
    task automatic cyc(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] wd,
                       input logic av, input logic [DW-1:0] as, input logic rdy);
        avl_read = rd; avl_write = wr; avl_address = a; avl_writedata = wd;
        adc_valid = av; adc_sample = as; dac_ready = rdy;
        @(negedge clk);
        avl_read = 1'b0; avl_write = 1'b0; adc_valid = 1'b0; dac_ready = 1'b0;
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
        cyc(1'b1, 1'b0, a, 32'd0, 1'b0, '0, 1'b0);
        d = avl_readdata;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0, '0, 1'b0);
    endtask

    task automatic adc_pulse(input logic [DW-1:0] s);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, s, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, '0, rdy);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apply_reset();
        n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL rst_dac_valid: got %b expected 0", dac_valid); end
        n_cmp++; if (cfg_gain !== 32'd1) begin n_err++; $display("FAIL rst_gain: got %h expected 1", cfg_gain); end
        n_cmp++; if (cfg_boost !== 32'd0 || cfg_bypass !== 1'b0) begin n_err++; $display("FAIL rst_boost_bypass: got %h/%b expected 0/0", cfg_boost, cfg_bypass); end
        n_cmp++; if (avl_readdata !== 32'd0) begin n_err++; $display("FAIL rst_readdata: got %h expected 0", avl_readdata); end
        rd_reg(5'd0, d);
        n_cmp++; if (d !== ID) begin n_err++; $display("FAIL read_id: got %h expected %h", d, ID); end
        rd_reg(5'd1, d);
        n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL read_gain_rst: got %h expected 1", d); end
        rd_reg(5'd2, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL read_boost_rst: got %h expected 0", d); end
    endtask

    task automatic test_gain_dac();
        logic [31:0] d;
        wr_reg(5'd1, 32'd2);
        n_cmp++; if (cfg_gain !== 32'd2) begin n_err++; $display("FAIL cfg_gain_write: got %h expected 2", cfg_gain); end
        wr_reg(5'd5, 32'd10);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            n_cmp++;
            if (dac_valid !== 1'b1 || dac_sample !== 16'd10) begin
                n_err++; $display("FAIL dac_hold[%0d]: got valid=%b sample=%h expected 1/000a", i, dac_valid, dac_sample);
            end
        end
        idle(1'b1);
        n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL dac_accept: got %b expected 0", dac_valid); end
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL status_after_accept: got %h expected 0", d); end
    endtask

    task automatic test_adc_sign();
        logic [31:0] d;
        wr_reg(5'd4, 32'd1);
        adc_pulse(16'hFFEC);
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL adc_status: got %h expected 1", d); end
        rd_reg(5'd6, d);
        n_cmp++; if (d !== 32'hFFFF_FFEC) begin n_err++; $display("FAIL adc_sext: got %h expected ffffffec", d); end
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL adc_status_cleared: got %h expected 0", d); end
    endtask

    task automatic test_in_overrun();
        logic [31:0] d;
        adc_pulse(16'd20);
        adc_pulse(16'd30);
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL in_ovr_status: got %h expected 3", d); end
        wr_reg(5'd3, 32'd2);
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL in_ovr_w1c: got %h expected 1", d); end
        cyc(1'b0, 1'b1, 5'd3, 32'd2, 1'b1, 16'd40, 1'b0);
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL in_ovr_set_wins: got %h expected 3", d); end
        rd_reg(5'd6, d);
        n_cmp++; if (d !== 32'd40) begin n_err++; $display("FAIL in_overwrite: got %h expected 28", d); end
        wr_reg(5'd3, 32'd2);
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL in_ovr_cleared: got %h expected 0", d); end
    endtask

    task automatic test_coincident_read();
        logic [31:0] d;
        adc_pulse(16'd50);
        cyc(1'b1, 1'b0, 5'd6, 32'd0, 1'b1, 16'd60, 1'b0);
        n_cmp++; if (avl_readdata !== 32'd50) begin n_err++; $display("FAIL coinc_old_sample: got %h expected 32", avl_readdata); end
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL coinc_status: got %h expected 1", d); end
        rd_reg(5'd6, d);
        n_cmp++; if (d !== 32'd60) begin n_err++; $display("FAIL coinc_new_sample: got %h expected 3c", d); end
    endtask

    task automatic test_dac_overrun();
        logic [31:0] d;
        wr_reg(5'd5, 32'd5);
        wr_reg(5'd5, 32'd7);
        n_cmp++; if (dac_sample !== 16'd5 || dac_valid !== 1'b1) begin n_err++; $display("FAIL dac_drop: got %h/%b expected 0005/1", dac_sample, dac_valid); end
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd12) begin n_err++; $display("FAIL out_ovr_status: got %h expected c", d); end
        idle(1'b1);
        wr_reg(5'd3, 32'd8);
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL out_ovr_w1c: got %h expected 0", d); end
        wr_reg(5'd5, 32'd5);
        cyc(1'b0, 1'b1, 5'd5, 32'd7, 1'b0, '0, 1'b1);
        n_cmp++; if (dac_sample !== 16'd7 || dac_valid !== 1'b1) begin n_err++; $display("FAIL dac_handoff: got %h/%b expected 0007/1", dac_sample, dac_valid); end
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd4) begin n_err++; $display("FAIL handoff_status: got %h expected 4", d); end
        idle(1'b1);
    endtask

    task automatic test_rw_collide();
        logic [31:0] d;
        rd_reg(5'd1, d);
        cyc(1'b1, 1'b1, 5'd2, 32'h1234, 1'b0, '0, 1'b0);
        n_cmp++; if (avl_readdata !== 32'd2 || cfg_boost !== 32'h1234) begin n_err++; $display("FAIL rw_collide: got rd=%h boost=%h expected 2/1234", avl_readdata, cfg_boost); end
    endtask

    task automatic test_disable();
        logic [31:0] d;
        wr_reg(5'd4, 32'd2);
        n_cmp++; if (cfg_bypass !== 1'b1) begin n_err++; $display("FAIL bypass: got %b expected 1", cfg_bypass); end
        adc_pulse(16'd99);
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL disabled_adc: got %h expected 0", d); end
        rd_reg(5'd4, d);
        n_cmp++; if (d !== 32'd2) begin n_err++; $display("FAIL control_read: got %h expected 2", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr_reg(5'd1, 32'd9);
        wr_reg(5'd4, 32'd1);
        adc_pulse(16'd77);
        wr_reg(5'd5, 32'd3);
        rd_reg(5'd0, d);
        avl_read = 1'b1; avl_address = 5'd0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (dac_valid !== 1'b0 || cfg_gain !== 32'd1) begin n_err++; $display("FAIL async_reset: got valid=%b gain=%h expected 0/1", dac_valid, cfg_gain); end
        n_cmp++; if (avl_readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata: got %h expected 0", avl_readdata); end
        @(negedge clk);
        avl_read = 1'b0; reset = 1'b0;
        rd_reg(5'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h expected 0", d); end
        rd_reg(5'd6, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_input: got %h expected 0", d); end
    endtask

    task automatic test_random();
        logic [31:0] m_gain, m_boost, exp_rd;
        logic m_en, m_byp, m_full, in_ovr, out_ovr, en_pre, rd, wr, av, rdy, read_in;
        logic [DW-1:0] m_val, m_dac, as;
        logic [DW-1:0] outq[$];
        logic [4:0] a;
        logic [31:0] wd;
        int k;
        apply_reset();
        m_gain = 32'd1; m_boost = 0; m_en = 0; m_byp = 0; m_full = 0; in_ovr = 0; out_ovr = 0;
        m_val = '0; m_dac = '0; exp_rd = 0; outq.delete();
        for (int it = 0; it < 400; it++) begin
            rd  = ($urandom_range(0, 2) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            k   = $urandom_range(0, 8);
            a   = (k == 8) ? 5'd9 : 5'(k);
            wd  = $urandom;
            av  = ($urandom_range(0, 1) == 1);
            as  = DW'($urandom);
            rdy = ($urandom_range(0, 3) == 0);
            en_pre = m_en;
            if (rd && !wr) begin
                case (a)
                    5'd0: exp_rd = ID;
                    5'd1: exp_rd = m_gain;
                    5'd2: exp_rd = m_boost;
                    5'd3: exp_rd = {28'd0, out_ovr, (outq.size() != 0), in_ovr, m_full};
                    5'd4: exp_rd = {30'd0, m_byp, m_en};
                    5'd6: exp_rd = sext(m_val);
                    default: exp_rd = 32'd0;
                endcase
            end
            if (wr) begin
                case (a)
                    5'd1: m_gain = wd;
                    5'd2: m_boost = wd;
                    5'd3: begin if (wd[1]) in_ovr = 0; if (wd[3]) out_ovr = 0; end
                    5'd4: begin m_en = wd[0]; m_byp = wd[1]; end
                    default: ;
                endcase
            end
            read_in = rd && !wr && a == 5'd6;
            if (en_pre && av) begin
                if (m_full && !read_in) in_ovr = 1;
                m_full = 1; m_val = as;
            end else if (read_in) begin
                m_full = 0;
            end
            if (rdy && outq.size() > 0) void'(outq.pop_front());
            if (wr && a == 5'd5) begin
                if (outq.size() == 0) begin outq.push_back(wd[DW-1:0]); m_dac = wd[DW-1:0]; end
                else out_ovr = 1;
            end
            cyc(rd, wr, a, wd, av, as, rdy);
            n_cmp++;
            if (avl_readdata !== exp_rd) begin n_err++; $display("FAIL rand_readdata[%0d]: got %h expected %h", it, avl_readdata, exp_rd); end
            n_cmp++;
            if (dac_valid !== (outq.size() != 0) || dac_sample !== m_dac) begin
                n_err++; $display("FAIL rand_dac[%0d]: got %b/%h expected %b/%h", it, dac_valid, dac_sample, (outq.size() != 0), m_dac);
            end
            n_cmp++;
            if (cfg_gain !== m_gain || cfg_boost !== m_boost || cfg_bypass !== m_byp) begin
                n_err++; $display("FAIL rand_cfg[%0d]: got %h/%h/%b expected %h/%h/%b", it, cfg_gain, cfg_boost, cfg_bypass, m_gain, m_boost, m_byp);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_gain_dac();
        test_adc_sign();
        test_in_overrun();
        test_coincident_read();
        test_dac_overrun();
        test_rw_collide();
        test_disable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
